// File: rtl/sha2_msg_scheduler_stream.sv
// SHA-2 message schedule generator: loads one 16-word block, then streams W[0..ROUNDS-1]
// from a 16-entry circular buffer over a valid/ready port.
module sha2_msg_scheduler_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WORD_W-1:0] load_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_round,
    output logic              w_last,
    output logic              busy
);

    localparam bool_sha512 = (WORD_W == 64);
    localparam int unsigned S0_R1 = bool_sha512 ? 1  : 7;
    localparam int unsigned S0_R2 = bool_sha512 ? 8  : 18;
    localparam int unsigned S0_SH = bool_sha512 ? 7  : 3;
    localparam int unsigned S1_R1 = bool_sha512 ? 19 : 17;
    localparam int unsigned S1_R2 = bool_sha512 ? 61 : 19;
    localparam int unsigned S1_SH = bool_sha512 ? 6  : 10;
    localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] buf_q [16];

    logic              buf_we;
    logic [3:0]        buf_widx;
    logic [WORD_W-1:0] buf_wdata;
    logic [WORD_W-1:0] w_calc;
    logic [3:0]        t_lo, idx_m2, idx_m7, idx_m15;
    logic              run;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // buf[t%16] still holds W[t-16] until it is overwritten by W[t] on the handshake.
    assign t_lo    = t_q[3:0];
    assign idx_m2  = t_lo - 4'd2;
    assign idx_m7  = t_lo - 4'd7;
    assign idx_m15 = t_lo - 4'd15;

    always_comb begin
        if (t_q < 7'd16) begin
            w_calc = buf_q[t_lo];
        end else begin
            w_calc = sig1(buf_q[idx_m2]) + buf_q[idx_m7] + sig0(buf_q[idx_m15]) + buf_q[t_lo];
        end
    end

    assign run        = (state_q == ST_RUN);
    assign load_ready = !run;
    assign w_valid    = run;
    assign w_data     = run ? w_calc : '0;
    assign w_round    = run ? t_q : '0;
    assign w_last     = run && (t_q == LAST_T);
    assign busy       = run || (load_cnt_q != 4'd0);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        buf_we     = 1'b0;
        buf_widx   = load_cnt_q;
        buf_wdata  = load_data;

        if (abort) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            t_d        = '0;
        end else if (!run && load_valid) begin
            buf_we     = 1'b1;
            load_cnt_d = load_cnt_q + 4'd1;
            if (load_cnt_q == 4'd15) begin
                state_d = ST_RUN;
                t_d     = '0;
            end
        end else if (run && w_ready) begin
            if (t_q >= 7'd16) begin
                buf_we    = 1'b1;
                buf_widx  = t_lo;
                buf_wdata = w_calc;
            end
            if (t_q == LAST_T) begin
                state_d    = ST_LOAD;
                load_cnt_d = '0;
                t_d        = '0;
            end else begin
                t_d = t_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            t_q        <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            if (buf_we) begin
                buf_q[buf_widx] <= buf_wdata;
            end
        end
    end

endmodule
